// File: rtl/uart_pkg.sv
// Shared state encoding, defaults and small helpers for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [3:0] DROP_TIMEOUT_DEF = 4'd15;
  localparam logic [3:0] BAUD_RST_DEF     = 4'b1011;

  typedef struct packed {
    logic       eight;
    logic       pen;
    logic       ohel;
    logic [3:0] baud;
  } frame_cfg_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: one-hot grant from the request pair and the last winner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte requesters onto one UART transmitter and owns the
// active frame configuration, which only changes while the transmitter is idle.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter logic [3:0] DROP_TIMEOUT = DROP_TIMEOUT_DEF,
  parameter logic [3:0] BAUD_RST     = BAUD_RST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  input  logic       cfg_wr,
  input  logic       cfg_eight,
  input  logic       cfg_pen,
  input  logic       cfg_ohel,
  input  logic [3:0] cfg_baud,
  input  logic       TxRdy,
  output logic       load,
  output logic [7:0] outPort,
  output logic       eight,
  output logic       pen,
  output logic       ohel,
  output logic [3:0] baud,
  output logic       busy,
  output logic       err
);

  state_t     state;
  state_t     next_state;
  logic [1:0] gnt;
  logic       last_grant;
  logic       cfg_pend;
  frame_cfg_t shadow;
  logic [3:0] cnt;
  logic       do_apply;
  logic       do_grant;
  logic       do_timeout;
  logic       cnt_clr;
  logic       cnt_inc;

  rr_arb2 u_arb (
    .req        ({req1, req0}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (do_grant) next_state = LOAD;
        else          next_state = IDLE;
      end
      LOAD:      next_state = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!TxRdy)          next_state = WAIT_DONE;
        else if (do_timeout) next_state = IDLE;
        else                 next_state = WAIT_BUSY;
      end
      WAIT_DONE: begin
        if (TxRdy) next_state = IDLE;
        else       next_state = WAIT_DONE;
      end
      default:   next_state = IDLE;
    endcase
  end

  // FSM decode: a pending config takes the idle cycle ahead of any grant.
  always_comb begin
    do_apply   = 1'b0;
    do_grant   = 1'b0;
    do_timeout = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        do_apply = cfg_pend;
        do_grant = !cfg_pend && TxRdy && (req0 || req1);
      end
      LOAD:      cnt_clr = 1'b1;
      WAIT_BUSY: begin
        cnt_inc    = 1'b1;
        do_timeout = TxRdy && (sat_inc4(cnt) >= DROP_TIMEOUT);
      end
      WAIT_DONE: cnt_inc = 1'b0;
      default:   cnt_clr = 1'b1;
    endcase
  end

  // Registered outputs, arbitration history, shadow config and timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      outPort    <= 8'h00;
      last_grant <= 1'b1;
      cfg_pend   <= 1'b0;
      shadow     <= '{eight: 1'b0, pen: 1'b0, ohel: 1'b0, baud: BAUD_RST};
      eight      <= 1'b0;
      pen        <= 1'b0;
      ohel       <= 1'b0;
      baud       <= BAUD_RST;
      cnt        <= 4'd0;
    end else begin
      load <= do_grant;
      ack0 <= do_grant & gnt[0];
      ack1 <= do_grant & gnt[1];
      busy <= (next_state != IDLE);
      if (do_grant) begin
        outPort    <= gnt[1] ? data1 : data0;
        last_grant <= gnt[1];
      end
      // A write in the same cycle as an apply stays pending so the newest value wins.
      if (cfg_wr) begin
        shadow   <= '{eight: cfg_eight, pen: cfg_pen, ohel: cfg_ohel, baud: cfg_baud};
        cfg_pend <= 1'b1;
      end else if (do_apply) begin
        cfg_pend <= 1'b0;
      end
      if (do_apply) begin
        eight <= shadow.eight;
        pen   <= shadow.pen;
        ohel  <= shadow.ohel;
        baud  <= shadow.baud;
      end
      if (do_timeout) begin
        err <= 1'b1;
      end
      if (cnt_clr) begin
        cnt <= 4'd0;
      end else if (cnt_inc) begin
        cnt <= sat_inc4(cnt);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a round-robin/config model predicts each
// grant, and a negedge monitor checks every ack/load the DUT produces.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1;
  logic       cfg_wr = 1'b0, cfg_eight = 1'b0, cfg_pen = 1'b0, cfg_ohel = 1'b0;
  logic [3:0] cfg_baud = 4'h0;
  logic       TxRdy = 1'b1;
  logic       load;
  logic [7:0] outPort;
  logic       eight, pen, ohel;
  logic [3:0] baud;
  logic       busy, err;
  logic [6:0] cfg_out;

  typedef struct {
    logic       port;
    logic [7:0] data;
    logic [6:0] cfg;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         last_winner = 1;
  logic [6:0] model_cfg   = 7'b000_1011;
  logic [6:0] applied_cfg = 7'b000_1011;
  bit         pend = 1'b0;

  assign cfg_out = {eight, pen, ohel, baud};

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .cfg_wr    (cfg_wr),
    .cfg_eight (cfg_eight),
    .cfg_pen   (cfg_pen),
    .cfg_ohel  (cfg_ohel),
    .cfg_baud  (cfg_baud),
    .TxRdy     (TxRdy),
    .load      (load),
    .outPort   (outPort),
    .eight     (eight),
    .pen       (pen),
    .ohel      (ohel),
    .baud      (baud),
    .busy      (busy),
    .err       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack/load must match the oldest predicted grant.
  always @(negedge clk) begin
    if (!rst && (load || ack0 || ack1)) begin
      check("ack_not_both", {31'd0, ack0 & ack1}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack_load", {29'd0, load, ack1, ack0}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", {30'd0, ack1, ack0}, e.port ? 32'd2 : 32'd1);
        check("load_with_ack", {31'd0, load}, 32'd1);
        check("outport", {24'd0, outPort}, {24'd0, e.data});
        check("cfg_at_grant", {25'd0, cfg_out}, {25'd0, e.cfg});
      end
    end
  end

  // Reference model: round robin over the last winner; newest config applies before the grant.
  task automatic push_expect(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1);
    exp_t e;
    if (r0 && r1) e.port = (last_winner == 1) ? 1'b0 : 1'b1;
    else          e.port = r1;
    last_winner = e.port ? 1 : 0;
    e.data      = e.port ? d1 : d0;
    applied_cfg = model_cfg;
    pend        = 1'b0;
    e.cfg       = applied_cfg;
    sb.push_back(e);
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic issue(input logic r0, input logic r1, input logic [7:0] d0, input logic [7:0] d1,
                       input int gap);
    int lat;
    int exp_lat;
    repeat (gap) @(negedge clk);
    exp_lat = (pend && gap == 0) ? 2 : 1;
    push_expect(r0, r1, d0, d1);
    req0 = r0; req1 = r1; data0 = d0; data1 = d1;
    wait_ack(lat);
    req0 = 1'b0; req1 = 1'b0;
    check("grant_latency", lat, exp_lat);
  endtask

  task automatic finish_frame(input int low, input bit wr, input logic [6:0] ncfg);
    TxRdy = 1'b0;
    for (int k = 0; k < low; k++) begin
      @(negedge clk);
      if (k == 1 && wr) begin
        cfg_wr = 1'b1;
        {cfg_eight, cfg_pen, cfg_ohel, cfg_baud} = ncfg;
      end else begin
        cfg_wr = 1'b0;
      end
      if (k >= 2 && wr) check("cfg_hold_busy", {25'd0, cfg_out}, {25'd0, applied_cfg});
    end
    if (wr) begin
      model_cfg = ncfg;
      pend      = 1'b1;
    end
    TxRdy = 1'b1;
    @(negedge clk);
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("cfg_hold_until_idle", {25'd0, cfg_out}, {25'd0, applied_cfg});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] r;
    logic [7:0] d0, d1;
    logic [6:0] ncfg;
    bit wr;
    int low;
    int gap;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_outputs", {28'd0, load, ack0, ack1, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_outport", {24'd0, outPort}, 32'd0);
    check("rst_cfg", {25'd0, cfg_out}, 32'h0B);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single request, transmitter busy for three cycles
    issue(1'b1, 1'b0, 8'h43, 8'h00, 0);
    finish_frame(3, 1'b0, 7'd0);
    check("outport_hold", {24'd0, outPort}, 32'h43);

    // Config written in WAIT_DONE: eight=1, pen=1, baud=3
    issue(1'b0, 1'b1, 8'h00, 8'h9E, 0);
    finish_frame(4, 1'b1, 7'b110_0011);
    issue(1'b1, 1'b0, 8'h11, 8'h00, 0);
    check("cfg_applied", {25'd0, cfg_out}, {25'd0, 7'b110_0011});
    finish_frame(2, 1'b0, 7'd0);

    // Timeout: TxRdy never falls after load
    issue(1'b1, 1'b0, 8'h77, 8'h00, 0);
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (err) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n < 15 || n > 17) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d expected 15..17 cycles after load", n);
    end
    check("timeout_busy", {31'd0, busy}, 32'd0);
    issue(1'b0, 1'b1, 8'h00, 8'h66, 0);
    finish_frame(2, 1'b0, 7'd0);
    check("err_sticky", {31'd0, err}, 32'd1);

    // Async reset in WAIT_DONE
    issue(1'b0, 1'b1, 8'h00, 8'h3C, 0);
    TxRdy = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_outputs", {28'd0, load, ack0, ack1, busy}, 32'd0);
    check("arst_err", {31'd0, err}, 32'd0);
    check("arst_outport", {24'd0, outPort}, 32'd0);
    check("arst_cfg", {25'd0, cfg_out}, 32'h0B);
    @(negedge clk);
    rst = 1'b0;
    TxRdy = 1'b1;
    last_winner = 1;
    model_cfg = 7'b000_1011;
    applied_cfg = 7'b000_1011;
    pend = 1'b0;
    check("arst_sb_empty", sb.size(), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("post_reset_quiet", {29'd0, load, ack1, ack0}, 32'd0);
    end

    // Tie: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, 8'hA5, 8'h5A, 0);
      check("tie_outport", {24'd0, outPort}, (i % 2 == 1) ? 32'h5A : 32'hA5);
      finish_frame(2, 1'b0, 7'd0);
    end

    // Stalled transmitter holds off the grant
    TxRdy = 1'b0;
    push_expect(1'b0, 1'b1, 8'h00, 8'hC3);
    req1 = 1'b1; data1 = 8'hC3;
    repeat (5) begin
      @(negedge clk);
      check("stall_no_ack", {30'd0, ack1, load}, 32'd0);
    end
    TxRdy = 1'b1;
    wait_ack(n);
    req1 = 1'b0;
    check("stall_latency", n, 32'd1);
    finish_frame(3, 1'b0, 7'd0);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      r    = 2'($urandom_range(1, 3));
      d0   = 8'($urandom);
      d1   = 8'($urandom);
      wr   = ($urandom_range(0, 2) == 0);
      low  = $urandom_range(2, 6);
      if (wr && low < 3) low = 3;
      ncfg = 7'($urandom);
      gap  = $urandom_range(0, 2);
      issue(r[0], r[1], d0, d1, gap);
      finish_frame(low, wr, ncfg);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
